sr_cmd_debouncer: RTL and testbench

Front-end stage that turns two raw, asynchronous push-button inputs into clean set/reset commands for the SR flip-flop. It synchronises each button, debounces it, and edge-detects the debounced level. It drives registered single-cycle `s`/`r` pulses straight into the flip-flop's `s`/`r` inputs. The block guarantees `s` and `r` are never high together, so the flip-flop's invalid 2'b11 case is unreachable from this path.

---
 rtl/sr_cmd_debouncer_if.sv | 27 ++
 rtl/sr_cmd_debouncer.sv | 96 +++++++++
 tb/tb_sr_cmd_debouncer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sr_cmd_debouncer_if.sv
// ---------------------------------------------------------------------------
// sr_cmd_debouncer_if
//   Bundle of the button inputs, enable and command/level outputs of the
//   SR-command debouncer.
//   master : drives en, set_btn, rst_btn; observes s, r, conflict, levels
//   slave  : the debouncer itself (inverse directions)
// ---------------------------------------------------------------------------
interface sr_cmd_debouncer_if;
  logic en;        // command enable
  logic set_btn;   // raw set button (asynchronous, may bounce)
  logic rst_btn;   // raw reset button (asynchronous, may bounce)
  logic s;         // one-cycle set command
  logic r;         // one-cycle reset command
  logic conflict;  // one-cycle pulse when both channels rise together
  logic set_lvl;   // debounced set level
  logic rst_lvl;   // debounced reset level

  modport master (
    output en, set_btn, rst_btn,
    input  s, r, conflict, set_lvl, rst_lvl
  );

  modport slave (
    input  en, set_btn, rst_btn,
    output s, r, conflict, set_lvl, rst_lvl
  );
endinterface

// File: rtl/sr_cmd_debouncer.sv
// ---------------------------------------------------------------------------
// sr_cmd_debouncer
//   Turns two raw push buttons into clean, mutually exclusive one-cycle set
//   and reset commands for an SR flip-flop. Each button is synchronised
//   (2 flops), debounced (DEBOUNCE_CYCLES consecutive differing samples are
//   needed to move the level) and rising-edge detected.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset, clears every flop
//     bus  - sr_cmd_debouncer_if.slave:
//              en, set_btn, rst_btn (in)
//              s, r, conflict, set_lvl, rst_lvl (out, all registered)
// ---------------------------------------------------------------------------
module sr_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_cmd_debouncer_if.slave    bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next mismatching sample commits the new level.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = set, channel 1 = reset.
  logic          btn       [2];
  logic          sync1_reg [2];
  logic          sync2_reg [2];
  logic [CW-1:0] cnt_reg   [2];
  logic          lvl_reg   [2];
  logic          lvl_d_reg [2];
  logic          rise      [2];

  logic s_reg;
  logic r_reg;
  logic conflict_reg;

  assign btn[0] = bus.set_btn;
  assign btn[1] = bus.rst_btn;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
          cnt_reg[gi]   <= '0;
          lvl_reg[gi]   <= 1'b0;
          lvl_d_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= btn[gi];
          sync2_reg[gi] <= sync1_reg[gi];
          lvl_d_reg[gi] <= lvl_reg[gi];
          if (sync2_reg[gi] != lvl_reg[gi]) begin
            // Counting toward a level change; commit on the Nth mismatch.
            if (cnt_reg[gi] == CNT_LAST) begin
              lvl_reg[gi] <= sync2_reg[gi];
              cnt_reg[gi] <= '0;
            end else begin
              cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
            end
          end else begin
            // Any agreeing sample discards a partial count (glitch rejected).
            cnt_reg[gi] <= '0;
          end
        end
      end

      // Only rising edges of the debounced level issue commands.
      assign rise[gi] = lvl_reg[gi] & ~lvl_d_reg[gi];
    end
  endgenerate

  // Simultaneous rises cancel each other and are flagged instead, so s and r
  // can never be high together. Rises while en=0 are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg        <= 1'b0;
      r_reg        <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      s_reg        <= bus.en & rise[0] & ~rise[1];
      r_reg        <= bus.en & rise[1] & ~rise[0];
      conflict_reg <= bus.en & rise[0] &  rise[1];
    end
  end

  assign bus.s        = s_reg;
  assign bus.r        = r_reg;
  assign bus.conflict = conflict_reg;
  assign bus.set_lvl  = lvl_reg[0];
  assign bus.rst_lvl  = lvl_reg[1];

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_debouncer
//   Directed bench for sr_cmd_debouncer with DEBOUNCE_CYCLES = 4.
//   Inputs change 1 ns after a rising edge; outputs are sampled at the same
//   point, i.e. they show the state after that edge. With a button changed
//   after edge E, the next edge is the first sample k, and a command is
//   expected after edge k+6, which is the 7th tick of a window.
// ---------------------------------------------------------------------------
module tb_sr_cmd_debouncer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sr_cmd_debouncer_if bus_if ();

  sr_cmd_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Runs n ticks and checks s/r/conflict each tick against the tick index
  // at which each pulse is expected (0 = never).
  task automatic window(input string tag, input int n,
                        input int s_at, input int r_at, input int c_at);
    for (int i = 1; i <= n; i++) begin
      tick();
      check($sformatf("%s.s@%0d", tag, i), bus_if.s, 1'(i == s_at));
      check($sformatf("%s.r@%0d", tag, i), bus_if.r, 1'(i == r_at));
      check($sformatf("%s.conflict@%0d", tag, i), bus_if.conflict, 1'(i == c_at));
    end
    $display("window %s: %0d cycles, checks=%0d errors=%0d", tag, n, checks, errors);
  endtask

  task automatic release_all(input string tag);
    bus_if.set_btn = 1'b0;
    bus_if.rst_btn = 1'b0;
    window({tag, ".release"}, 9, 0, 0, 0);
    check({tag, ".set_lvl_low"}, bus_if.set_lvl, 1'b0);
    check({tag, ".rst_lvl_low"}, bus_if.rst_lvl, 1'b0);
  endtask

  logic bounce [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset with set button already held.
    rst            = 1'b1;
    bus_if.en      = 1'b1;
    bus_if.set_btn = 1'b1;
    bus_if.rst_btn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset.s", bus_if.s, 1'b0);
      check("reset.r", bus_if.r, 1'b0);
      check("reset.conflict", bus_if.conflict, 1'b0);
      check("reset.set_lvl", bus_if.set_lvl, 1'b0);
      check("reset.rst_lvl", bus_if.rst_lvl, 1'b0);
    end
    rst = 1'b0;
    window("post_reset", 12, 7, 0, 0);
    check("post_reset.set_lvl", bus_if.set_lvl, 1'b1);
    release_all("post_reset");

    // Clean press held 20 cycles.
    bus_if.set_btn = 1'b1;
    window("clean", 20, 7, 0, 0);
    check("clean.set_lvl", bus_if.set_lvl, 1'b1);
    release_all("clean");

    // Bounce on the reset button, every run shorter than 4 samples.
    for (int i = 0; i < 9; i++) begin
      bus_if.rst_btn = bounce[i];
      tick();
      check($sformatf("bounce.r@%0d", i), bus_if.r, 1'b0);
      check($sformatf("bounce.rst_lvl@%0d", i), bus_if.rst_lvl, 1'b0);
    end
    bus_if.rst_btn = 1'b1;
    window("bounce_stable", 10, 0, 7, 0);
    check("bounce.rst_lvl", bus_if.rst_lvl, 1'b1);

    // Reset level still high, set pressed: a normal set command.
    bus_if.set_btn = 1'b1;
    window("held_other", 10, 7, 0, 0);
    check("held_other.rst_lvl", bus_if.rst_lvl, 1'b1);
    check("held_other.set_lvl", bus_if.set_lvl, 1'b1);
    release_all("held_other");

    // Both buttons rise together.
    bus_if.set_btn = 1'b1;
    bus_if.rst_btn = 1'b1;
    window("simul", 10, 0, 0, 7);
    release_all("simul");

    // Press with en=0, then enable while held: nothing is emitted.
    bus_if.en      = 1'b0;
    bus_if.set_btn = 1'b1;
    window("gated", 10, 0, 0, 0);
    check("gated.set_lvl", bus_if.set_lvl, 1'b1);
    bus_if.en = 1'b1;
    window("gated_en", 10, 0, 0, 0);
    release_all("gated");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
